// File: rtl/vector_serializer.sv
// vector_serializer: captures one LANES-wide vector and streams its lanes out one beat at a time over valid/ready.
module vector_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES = 3,
  parameter int CNT_W = 16,
  localparam int IDX_W = $clog2(LANES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] vec_in,
  input  logic                             vec_valid,
  output logic                             vec_take,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [IDX_W-1:0]                 m_idx,
  output logic                             m_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [CNT_W-1:0]                 vec_count
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [DATA_WIDTH-1:0] lane_buf [LANES];
  logic beat, last_beat;
  always_comb begin
    m_valid = rst_n && state == STREAM;
    beat = m_valid && m_ready;
    last_beat = beat && idx == LAST_IDX;
    vec_take = rst_n && vec_valid && (state == IDLE || last_beat);
    m_data = m_valid ? lane_buf[idx] : '0;
    m_idx = m_valid ? idx : '0;
    m_last = m_valid && idx == LAST_IDX;
    state_nxt = vec_take ? STREAM : last_beat ? IDLE : state;
    idx_nxt = (vec_take || last_beat) ? '0 : beat ? idx + 1'b1 : idx;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      vec_count <= '0;
    end else begin
      state <= state_nxt;
      idx <= idx_nxt;
      vec_count <= vec_count + CNT_W'(last_beat);
    end
  end
  // Lane buffer is only written on a take, so it stays untouched mid-vector.
  always_ff @(posedge clk) begin
    if (vec_take)
      for (int i = 0; i < LANES; i++) lane_buf[i] <= vec_in[i];
  end
endmodule

// File: tb/tb_vector_serializer.sv
// tb_vector_serializer: directed checks of capture, streaming, backpressure, back-to-back, reset and counter wrap.
module tb_vector_serializer;
  logic clk = 0;
  logic rst_n = 0;
  logic [2:0][31:0] vec_in = '0;
  logic vec_valid = 0;
  logic vec_take;
  logic [31:0] m_data;
  logic [1:0] m_idx;
  logic m_last, m_valid;
  logic m_ready = 0;
  logic [1:0] vec_count;
  int checks = 0;
  int errors = 0;
  vector_serializer #(.DATA_WIDTH(32), .LANES(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .vec_in(vec_in), .vec_valid(vec_valid),
    .vec_take(vec_take), .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .vec_count(vec_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic beat_chk(input string tag, input logic [31:0] d, input logic [1:0] i, input logic l);
    #2;
    chk({tag, "_valid"}, m_valid, 1);
    chk({tag, "_data"}, m_data, d);
    chk({tag, "_idx"}, m_idx, i);
    chk({tag, "_last"}, m_last, l);
  endtask
  task automatic send_vec(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    vec_in = {c, b, a};
    vec_valid = 1;
    m_ready = 1;
    #2;
    chk({tag, "_take"}, vec_take, 1);
    chk({tag, "_idle"}, m_valid, 0);
    cyc;
    vec_valid = 0;
    vec_in = '0;
    beat_chk({tag, "_l0"}, a, 0, 0);
    cyc;
    beat_chk({tag, "_l1"}, b, 1, 0);
    cyc;
    beat_chk({tag, "_l2"}, c, 2, 1);
    cyc;
    #2;
    chk({tag, "_done"}, m_valid, 0);
  endtask
  initial begin
    logic rdy [6] = '{1, 0, 0, 1, 0, 1};
    logic [1:0] eidx [6] = '{0, 1, 1, 1, 2, 2};
    logic [31:0] edat [3] = '{32'h11, 32'h22, 32'h33};
    logic [1:0] ecnt [5] = '{1, 2, 3, 0, 1};
    // reset with vec_valid high
    vec_valid = 1;
    vec_in = {32'hC, 32'hB, 32'hA};
    #2;
    chk("rst_take", vec_take, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    cyc;
    cyc;
    chk("rst_count", vec_count, 0);
    chk("rst_take2", vec_take, 0);
    vec_valid = 0;
    rst_n = 1;
    cyc;
    // single vector
    send_vec("single", 32'hA, 32'hB, 32'hC);
    chk("single_count", vec_count, 1);
    // backpressure
    vec_in = {32'h33, 32'h22, 32'h11};
    vec_valid = 1;
    m_ready = 1;
    #2;
    chk("bp_take", vec_take, 1);
    cyc;
    vec_valid = 0;
    vec_in = '0;
    for (int k = 0; k < 6; k++) begin
      m_ready = rdy[k];
      beat_chk($sformatf("bp%0d", k), edat[eidx[k]], eidx[k], eidx[k] == 2);
      cyc;
    end
    #2;
    chk("bp_done", m_valid, 0);
    chk("bp_count", vec_count, 2);
    // back-to-back
    vec_in = {32'hC, 32'hB, 32'hA};
    vec_valid = 1;
    m_ready = 1;
    cyc;
    vec_in = {32'hF, 32'hE, 32'hD};
    beat_chk("b2b_a", 32'hA, 0, 0);
    chk("b2b_take_a", vec_take, 0);
    cyc;
    beat_chk("b2b_b", 32'hB, 1, 0);
    chk("b2b_take_b", vec_take, 0);
    cyc;
    beat_chk("b2b_c", 32'hC, 2, 1);
    chk("b2b_take_c", vec_take, 1);
    cyc;
    vec_valid = 0;
    vec_in = '0;
    beat_chk("b2b_d", 32'hD, 0, 0);
    chk("b2b_count_c", vec_count, 3);
    cyc;
    beat_chk("b2b_e", 32'hE, 1, 0);
    cyc;
    beat_chk("b2b_f", 32'hF, 2, 1);
    cyc;
    #2;
    chk("b2b_done", m_valid, 0);
    chk("b2b_wrap", vec_count, 0);
    // reset mid-vector
    vec_in = {32'hC, 32'hB, 32'hA};
    vec_valid = 1;
    cyc;
    vec_valid = 0;
    beat_chk("mid_a", 32'hA, 0, 0);
    cyc;
    rst_n = 0;
    #2;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_idx", m_idx, 0);
    cyc;
    rst_n = 1;
    #2;
    chk("mid_post_valid", m_valid, 0);
    chk("mid_post_count", vec_count, 0);
    cyc;
    send_vec("xyz", 32'h58, 32'h59, 32'h5A);
    chk("xyz_count", vec_count, 1);
    // counter wrap
    rst_n = 0;
    cyc;
    rst_n = 1;
    cyc;
    for (int k = 0; k < 5; k++) begin
      send_vec($sformatf("wrap%0d", k), 32'h100 + k, 32'h200 + k, 32'h300 + k);
      chk($sformatf("wrap%0d_count", k), vec_count, ecnt[k]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
